// File: rtl/bpd_tourn_param.sv
// rtl/bpd_tourn_param.sv - parametrised tournament branch direction predictor (f0/f1 fetch pipe)
module bpd_tourn_param #(
    parameter int PC_W      = 64,
    parameter int GHR_W     = 12,
    parameter int LHIST_W   = 10,
    parameter int BHT_IDX_W = 10,
    parameter int CH_IDX_W  = 12,
    parameter int GCNT_W    = 2,
    parameter int LCNT_W    = 3,
    parameter int CCNT_W    = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [PC_W-1:0]      pc_f0_i,
    input  logic [PC_W-1:0]      pc_f1_i,
    input  logic                 pipe_ctrl_fetch_i,
    input  logic                 condbr_f1_i,
    input  logic                 btb_brdir_f1_i,
    input  logic [PC_W-1:0]      pc_f1_t_i,
    input  logic [PC_W-1:0]      pc_f1_nt_i,
    input  logic [1:0]           mode_i,
    input  logic                 flush_i,
    input  logic                 rt_valid_i,
    input  logic [PC_W-1:0]      rt_pc_i,
    input  logic [GHR_W-1:0]     rt_ghr_i,
    input  logic [LHIST_W-1:0]   rt_lochist_i,
    input  logic                 rt_brdir_i,
    input  logic                 rt_gpred_i,
    input  logic                 rt_lpred_i,
    output logic                 ready_o,
    output logic                 final_pred_o,
    output logic                 gpred_o,
    output logic                 lpred_o,
    output logic [GHR_W-1:0]     ghr_o,
    output logic [LHIST_W-1:0]   lochist_f1_o,
    output logic                 override_o,
    output logic [PC_W-1:0]      override_pc_o
);

    // Sweep length covers the largest table; smaller tables stop being written early.
    localparam int M_A = (GHR_W > LHIST_W) ? GHR_W : LHIST_W;
    localparam int M_B = (BHT_IDX_W > CH_IDX_W) ? BHT_IDX_W : CH_IDX_W;
    localparam int M   = (M_A > M_B) ? M_A : M_B;

    // Post-reset contents: choice weakly global, direction counters weakly not-taken.
    localparam logic [CCNT_W-1:0] CH_INIT  = {1'b1, {(CCNT_W-1){1'b0}}};
    localparam logic [GCNT_W-1:0] GSH_INIT = {1'b0, {(GCNT_W-1){1'b1}}};
    localparam logic [LCNT_W-1:0] LOC_INIT = {1'b0, {(LCNT_W-1){1'b1}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state;
    logic [M-1:0]       idx;
    logic [GHR_W-1:0]   ghr;
    logic               ch_f1;
    logic [LHIST_W-1:0] lochist_f1;

    logic [GCNT_W-1:0]  gsh_pht [2**GHR_W];
    logic [LCNT_W-1:0]  loc_pht [2**LHIST_W];
    logic [LHIST_W-1:0] bht     [2**BHT_IDX_W];
    logic [CCNT_W-1:0]  ch_pht  [2**CH_IDX_W];

    logic [GHR_W-1:0]     gsh_f1_idx;
    logic [GHR_W-1:0]     gsh_rt_idx;
    logic [BHT_IDX_W-1:0] bht_rt_idx;
    logic [CH_IDX_W-1:0]  ch_rt_idx;
    logic [GCNT_W-1:0]    gsh_old, gsh_new;
    logic [LCNT_W-1:0]    loc_old, loc_new;
    logic [CCNT_W-1:0]    ch_old, ch_new;
    logic [LHIST_W-1:0]   bht_new;
    logic                 ch_upd;
    logic                 in_g, in_l, in_b, in_c;
    logic                 pred_sel;
    logic                 unused_pc_bits;

    assign ready_o      = (state == ST_RUN);
    assign ghr_o        = ghr;
    assign lochist_f1_o = lochist_f1;

    assign in_g = ((idx >> GHR_W) == '0);
    assign in_l = ((idx >> LHIST_W) == '0);
    assign in_b = ((idx >> BHT_IDX_W) == '0);
    assign in_c = ((idx >> CH_IDX_W) == '0);

    assign gsh_f1_idx = pc_f1_i[GHR_W+1:2] ^ ghr;
    assign gpred_o    = gsh_pht[gsh_f1_idx][GCNT_W-1];
    assign lpred_o    = loc_pht[lochist_f1][LCNT_W-1];

    assign gsh_rt_idx = rt_pc_i[GHR_W+1:2] ^ rt_ghr_i;
    assign bht_rt_idx = rt_pc_i[BHT_IDX_W+1:2];
    assign ch_rt_idx  = rt_pc_i[CH_IDX_W+1:2];
    assign gsh_old    = gsh_pht[gsh_rt_idx];
    assign loc_old    = loc_pht[rt_lochist_i];
    assign ch_old     = ch_pht[ch_rt_idx];
    assign bht_new    = {bht[bht_rt_idx][LHIST_W-2:0], rt_brdir_i};
    assign ch_upd     = (rt_gpred_i != rt_lpred_i);

    assign unused_pc_bits = ^{pc_f0_i, pc_f1_i, rt_pc_i};

    // Saturating next values for the retiring branch's counters.
    always_comb begin
        gsh_new = gsh_old;
        loc_new = loc_old;
        ch_new  = ch_old;
        if (rt_brdir_i) begin
            if (!(&gsh_old)) gsh_new = gsh_old + 1'b1;
            if (!(&loc_old)) loc_new = loc_old + 1'b1;
        end else begin
            if (|gsh_old) gsh_new = gsh_old - 1'b1;
            if (|loc_old) loc_new = loc_old - 1'b1;
        end
        if (rt_gpred_i == rt_brdir_i) begin
            if (!(&ch_old)) ch_new = ch_old + 1'b1;
        end else begin
            if (|ch_old) ch_new = ch_old - 1'b1;
        end
    end

    // Mode-dependent final direction; forced not-taken until the tables are swept.
    always_comb begin
        pred_sel = 1'b0;
        case (mode_i)
            2'b00:   pred_sel = ch_f1 ? gpred_o : lpred_o;
            2'b01:   pred_sel = gpred_o;
            2'b10:   pred_sel = lpred_o;
            default: pred_sel = btb_brdir_f1_i;
        endcase
        final_pred_o  = ready_o & pred_sel;
        override_o    = ready_o & condbr_f1_i & (final_pred_o ^ btb_brdir_f1_i) & (mode_i != 2'b11);
        override_pc_o = final_pred_o ? pc_f1_t_i : pc_f1_nt_i;
    end

    // Control FSM: init sweep, speculative GHR with checkpoint restore first, f0->f1 registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            idx        <= '0;
            ghr        <= '0;
            ch_f1      <= 1'b0;
            lochist_f1 <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (&idx) state <= ST_RUN;
                    else      idx   <= idx + 1'b1;
                end
                default: begin
                    if (flush_i && rt_valid_i)
                        ghr <= {rt_ghr_i[GHR_W-2:0], rt_brdir_i};
                    else if (flush_i)
                        ghr <= rt_ghr_i;
                    else if (condbr_f1_i && pipe_ctrl_fetch_i)
                        ghr <= {ghr[GHR_W-2:0], final_pred_o};
                    if (pipe_ctrl_fetch_i) begin
                        ch_f1      <= ch_pht[pc_f0_i[CH_IDX_W+1:2]][CCNT_W-1];
                        lochist_f1 <= bht[pc_f0_i[BHT_IDX_W+1:2]];
                    end
                end
            endcase
        end
    end

    // Table writes: sweep values during INIT, retire updates in RUN (every mode).
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            if (in_g) gsh_pht[idx[GHR_W-1:0]]     <= GSH_INIT;
            if (in_l) loc_pht[idx[LHIST_W-1:0]]   <= LOC_INIT;
            if (in_b) bht[idx[BHT_IDX_W-1:0]]     <= '0;
            if (in_c) ch_pht[idx[CH_IDX_W-1:0]]   <= CH_INIT;
        end else if (rt_valid_i) begin
            gsh_pht[gsh_rt_idx]   <= gsh_new;
            loc_pht[rt_lochist_i] <= loc_new;
            bht[bht_rt_idx]       <= bht_new;
            if (ch_upd) ch_pht[ch_rt_idx] <= ch_new;
        end
    end

endmodule

// File: doc/bpd_tourn_param.md
Name: bpd_tourn_param

Overview:
Parametrised tournament branch direction predictor for the two-stage fetch pipe (f0/f1), successor to the fixed 12/10-bit predictor.
- Local side: per-PC history table (BHT) plus local PHT.
- Global side: gshare PHT indexed by PC xor speculative GHR.
- Choice PHT selects between local and global.
- New relative to the fixed predictor: all widths and counter sizes are parametrised; a runtime mode select; a post-reset table-initialisation sweep with a ready flag; a retire-side BHT shift computed inside the block; GHR restore priority corrected so checkpoint restore always wins.

Parameters:
PC_W, 64, PC width
GHR_W, 12, global history bits = gshare PHT index width (2^GHR_W entries)
LHIST_W, 10, local history bits = local PHT index width
BHT_IDX_W, 10, BHT index bits (2^BHT_IDX_W entries of LHIST_W bits)
CH_IDX_W, 12, choice PHT index bits
GCNT_W, 2, gshare counter width
LCNT_W, 3, local counter width
CCNT_W, 2, choice counter width

Ports:
clock  in  1  core clock
reset_n  in  1  async active-low reset
pc_f0_i  in  PC_W  fetch PC, stage f0
pc_f1_i  in  PC_W  fetch PC, stage f1
pipe_ctrl_fetch_i  in  1  f0->f1 advance enable
condbr_f1_i  in  1  f1 instruction is a conditional branch
btb_brdir_f1_i  in  1  BTB direction for f1
pc_f1_t_i  in  PC_W  taken target
pc_f1_nt_i  in  PC_W  fall-through PC
mode_i  in  2  00 tournament, 01 global only, 10 local only, 11 BTB only
flush_i  in  1  pipeline flush, restore GHR
rt_valid_i  in  1  retiring conditional branch update
rt_pc_i  in  PC_W  retiring branch PC
rt_ghr_i  in  GHR_W  GHR checkpoint of retiring/flushing branch
rt_lochist_i  in  LHIST_W  local history used at predict time
rt_brdir_i  in  1  resolved direction
rt_gpred_i  in  1  global prediction made at predict time
rt_lpred_i  in  1  local prediction made at predict time
ready_o  out  1  tables initialised
final_pred_o  out  1  final f1 direction
gpred_o  out  1  gshare prediction (f1)
lpred_o  out  1  local prediction (f1)
ghr_o  out  GHR_W  current speculative GHR
lochist_f1_o  out  LHIST_W  f1 local history (checkpointed by the branch buffer)
override_o  out  1  redirect fetch: predictor disagrees with BTB
override_pc_o  out  PC_W  redirect PC

Behaviour:
- Counter rule, all PHTs: predict taken = MSB. Update saturates: +1 toward taken, -1 toward not-taken, no wrap.
- Tables are register arrays with combinational read. A write takes effect at the clock edge; a same-cycle read of the same index returns the old value.
- FSM states: INIT, RUN.
  - reset_n low (async, any time, including mid-operation): enter INIT; sweep counter = 0; ghr = 0; f1 registers = 0.
  - INIT: one index per cycle, 0 .. 2^M-1, where M = max(GHR_W, LHIST_W, BHT_IDX_W, CH_IDX_W). Each table is written only while idx < its own size.
  - INIT write values: choice = 10..0 (weak global); gshare and local = 01..1 (weak not-taken); BHT = 0.
  - Leave INIT after idx 2^M-1 is written, i.e. 2^M cycles after reset release. RUN persists until the next reset.
- While ready_o = 0: ready_o, final_pred_o, override_o all 0; ghr held at 0; rt_valid_i, flush_i, pipe_ctrl_fetch_i ignored.
- Read path (RUN):
  - f0 reads BHT at pc_f0_i[BHT_IDX_W+1:2] and choice PHT at pc_f0_i[CH_IDX_W+1:2].
  - On pipe_ctrl_fetch_i, register the choice MSB and BHT entry into f1 (lochist_f1_o). Otherwise hold.
  - f1, combinational: gshare index = pc_f1_i[GHR_W+1:2] ^ ghr; local index = lochist_f1_o.
  - final_pred_o by mode:
    - 00: choice ? gpred : lpred
    - 01: gpred
    - 10: lpred
    - 11: btb_brdir_f1_i
  - override_o = ready_o & condbr_f1_i & (final_pred_o ^ btb_brdir_f1_i); forced 0 in mode 11.
  - override_pc_o = final_pred_o ? pc_f1_t_i : pc_f1_nt_i.
- GHR update (RUN), priority order:
  1. flush_i & rt_valid_i: ghr <= {rt_ghr_i[GHR_W-2:0], rt_brdir_i}.
  2. flush_i: ghr <= rt_ghr_i.
  3. condbr_f1_i & pipe_ctrl_fetch_i: ghr <= {ghr[GHR_W-2:0], final_pred_o}.
  4. Otherwise hold.
- Retire update (RUN & rt_valid_i), all tables in the same cycle; independent of flush_i:
  - gshare at rt_pc_i[GHR_W+1:2] ^ rt_ghr_i: update toward rt_brdir_i.
  - Local PHT at rt_lochist_i: update toward rt_brdir_i.
  - BHT at rt_pc_i[BHT_IDX_W+1:2]: entry <= {entry[LHIST_W-2:0], rt_brdir_i}, read-modify-write of the stored value.
  - Choice at rt_pc_i[CH_IDX_W+1:2], only if rt_gpred_i != rt_lpred_i: increment if rt_gpred_i == rt_brdir_i, else decrement.
- Updates are performed in every mode. mode_i affects only output selection.

Test Plan:
- Reset release with defaults -> ready_o = 0 for exactly 4096 cycles, then 1. Read-back: choice = 2'b10, gshare = 2'b01, local = 3'b011, BHT = 0. Reassert reset_n at cycle 2000 -> sweep restarts from 0.
- Mode 00, PC 0x1000, ghr 0, rt_valid_i with brdir = 1 twice at the same gshare index, rt_gpred_i = rt_lpred_i -> gshare 01->10->11, choice unchanged, gpred_o = 1. btb_brdir_f1_i = 0 with condbr_f1_i = 1 -> override_o = 1, override_pc_o = pc_f1_t_i.
- Retire brdir = 1 three times at PC 0x2000 -> BHT entry 0x000->0x001->0x003->0x007. Next fetch of 0x2000 -> lochist_f1_o = 0x007 after a pipe_ctrl_fetch_i edge.
- ghr = 0x0A5; assert flush_i & rt_valid_i with rt_ghr_i = 0x123, brdir = 1, and condbr_f1_i & pipe_ctrl_fetch_i in the same cycle -> ghr = 0x247. Flush alone -> ghr = 0x123.
- Choice counter at 11, retire with gpred = 1, lpred = 0, brdir = 1 -> stays 11 (saturates). Mode 11 with disagreeing tables -> final_pred_o = btb_brdir_f1_i, override_o = 0.
- pipe_ctrl_fetch_i = 0 while pc_f0_i changes -> lochist_f1_o and choice hold; ghr does not shift even with condbr_f1_i = 1.
